// File: rtl/charlieplex_scan.sv
// Charlieplex scan driver: 7 pins, 7 rows x 6 LEDs, Wishbone frame buffer and brightness.
// Optional per-slot dead time before the duty window is enabled by `define CHARLIEPLEX_BLANK_EN.
module charlieplex_scan #(
  parameter int SLOT_W = 10,
  parameter int BLANK  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [6:0] charlieplex_oe,
  output logic [6:0] charlieplex_o
);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } state_e;

  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK - 1);
`ifdef CHARLIEPLEX_BLANK_EN
  localparam state_e RESET_STATE = ST_BLANK;
  localparam bit     BLANK_ON    = (BLANK > 0);
`else
  localparam state_e RESET_STATE = ST_ON;
  localparam bit     BLANK_ON    = 1'b0;
`endif

  logic [SLOT_W-1:0] cnt_q, cnt_d;
  logic [2:0]        row_q, row_d;
  logic [6:0]        mask_q [7];
  logic [6:0]        mask_d [7];
  logic [7:0]        bright_q, bright_d;
  logic [6:0]        sh_mask_q, sh_mask_d;
  logic [7:0]        sh_bright_q, sh_bright_d;
  state_e            state_q, state_d;
  logic [6:0]        oe_q, oe_d;
  logic [6:0]        o_q, o_d;
  logic              ack_q, ack_d;
  logic [7:0]        dat_q, dat_d;

  logic       wb_req;
  logic       wb_wr;
  logic [7:0] rd_val;
  logic       wrap;
  logic       duty_next;
  logic [2:0] row_nxt;
  logic [6:0] row_bit;

  // Wishbone: a request is sampled only while no ack is outstanding, so a held
  // strobe acks every other cycle.
  always_comb begin
    wb_req = wb_cyc_i & wb_stb_i & ~ack_q;
    wb_wr  = wb_req & wb_we_i;
    rd_val = 8'h00;
    for (int i = 0; i < 7; i++) begin
      if (wb_adr_i == 3'(i)) rd_val = {1'b0, mask_q[i]};
    end
    if (wb_adr_i == 3'd7) rd_val = bright_q;
    ack_d    = wb_req;
    dat_d    = (wb_req & ~wb_we_i) ? rd_val : 8'h00;
    bright_d = bright_q;
    if (wb_wr && wb_adr_i == 3'd7) bright_d = wb_dat_i;
    for (int i = 0; i < 7; i++) begin
      mask_d[i] = mask_q[i];
      // A row never drives its own pin low, so its own column bit is dropped.
      if (wb_wr && wb_adr_i == 3'(i)) mask_d[i] = wb_dat_i[6:0] & ~(7'd1 << i);
    end
  end

  // Slot counter, row advance and shadow capture at the slot boundary.
  always_comb begin
    wrap        = &cnt_q;
    cnt_d       = cnt_q + SLOT_W'(1);
    row_nxt     = (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
    row_d       = row_q;
    sh_mask_d   = sh_mask_q;
    sh_bright_d = sh_bright_q;
    if (wrap) begin
      row_d       = row_nxt;
      sh_bright_d = bright_q;
      for (int i = 0; i < 7; i++) begin
        if (row_nxt == 3'(i)) sh_mask_d = mask_q[i];
      end
    end
    duty_next = (cnt_d[SLOT_W-1 -: 8] < sh_bright_d);
  end

  // state_q always describes the slot position held in cnt_q.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = duty_next ? ST_ON : ST_OFF;
      ST_ON:    if (!duty_next) state_d = ST_OFF;
      ST_OFF:   state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase
    if (wrap) begin
      if (BLANK_ON) state_d = ST_BLANK;
      else          state_d = duty_next ? ST_ON : ST_OFF;
    end
  end

  always_comb begin
    row_bit = 7'd1 << row_q;
    oe_d    = 7'h00;
    o_d     = 7'h00;
    if (state_q == ST_ON) begin
      oe_d = row_bit | sh_mask_q;
      o_d  = row_bit;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      row_q       <= 3'd0;
      for (int i = 0; i < 7; i++) mask_q[i] <= 7'h00;
      bright_q    <= 8'h80;
      sh_mask_q   <= 7'h00;
      sh_bright_q <= 8'h80;
      state_q     <= RESET_STATE;
      oe_q        <= 7'h00;
      o_q         <= 7'h00;
      ack_q       <= 1'b0;
      dat_q       <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      for (int i = 0; i < 7; i++) mask_q[i] <= mask_d[i];
      bright_q    <= bright_d;
      sh_mask_q   <= sh_mask_d;
      sh_bright_q <= sh_bright_d;
      state_q     <= state_d;
      oe_q        <= oe_d;
      o_q         <= o_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wb_ack_o       = ack_q;
  assign wb_dat_o       = dat_q;
  assign charlieplex_oe = oe_q;
  assign charlieplex_o  = o_q;

endmodule

// File: tb/tb_charlieplex_scan.sv
// Bench for charlieplex_scan: slot-position reference model, per-cycle compare,
// directed literal checks and randomized Wishbone traffic.
module tb_charlieplex_scan;
  localparam int SLOT_W = 8;
  localparam int BLANK  = 4;
  localparam int SLOT   = 1 << SLOT_W;
  localparam int FRAME  = 7 * SLOT;
`ifdef CHARLIEPLEX_BLANK_EN
  localparam int LIT_OFF = BLANK;
`else
  localparam int LIT_OFF = 0;
`endif

  logic       clk, rst_n, cyc, stb, we;
  logic [2:0] adr;
  logic [7:0] dat_w, dat_r;
  logic       ack;
  logic [6:0] oe, o;

  charlieplex_scan #(.SLOT_W(SLOT_W), .BLANK(BLANK)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .charlieplex_oe(oe), .charlieplex_o(o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: slot position and row, shadows taken at slot start
  logic [6:0] m_mask [7];
  logic [7:0] m_bright, m_sh_bright, m_dat;
  logic [6:0] m_sh_mask, m_oe, m_o;
  int         m_pos, m_row;
  logic       m_ack, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) m_mask[i] = 7'h00;
      m_bright = 8'h80; m_sh_bright = 8'h80; m_sh_mask = 7'h00;
      m_pos = 0; m_row = 0; m_ack = 1'b0; m_rd = 1'b0; m_dat = 8'h00;
      m_oe = 7'h00; m_o = 7'h00;
    end else begin : step
      logic lit, req;
      int   ai;
      lit = (m_pos < int'(m_sh_bright));
`ifdef CHARLIEPLEX_BLANK_EN
      if (m_pos < BLANK) lit = 1'b0;
`endif
      m_oe = lit ? ((7'd1 << m_row) | m_sh_mask) : 7'h00;
      m_o  = lit ? (7'd1 << m_row) : 7'h00;
      req  = cyc && stb && !m_ack;
      ai   = int'(adr);
      m_rd = req && !we;
      if (m_rd) m_dat = (ai == 7) ? m_bright : {1'b0, m_mask[ai]};
      if (m_pos == SLOT - 1) begin
        m_pos = 0;
        m_row = (m_row + 1) % 7;
        m_sh_mask   = m_mask[m_row];
        m_sh_bright = m_bright;
      end else begin
        m_pos++;
      end
      if (req && we) begin
        if (ai == 7) m_bright = dat_w;
        else begin
          m_mask[ai] = dat_w[6:0];
          m_mask[ai][ai] = 1'b0;
        end
      end
      m_ack = req;
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_oe", 12'(oe), 12'h0);
      chk("rst_o", 12'(o), 12'h0);
      chk("rst_ack", 12'(ack), 12'h0);
      chk("rst_dat", 12'(dat_r), 12'h0);
    end else begin
      chk("oe", 12'(oe), 12'(m_oe));
      chk("o", 12'(o), 12'(m_o));
      chk("ack", 12'(ack), 12'(m_ack));
      if (m_ack && m_rd) chk("rdata", 12'(dat_r), 12'(m_dat));
    end
  end

  // driver tasks
  task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] r);
    int k;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack && k < 8);
    if (!ack) chk("ack_timeout", 12'(ack), 12'h1);
    r = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_slot(input int r, input int p);
    int k;
    k = 0;
    while (!(m_row == r && m_pos == p) && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4 * FRAME) chk("slot_timeout", 12'(k), 12'h0);
  endtask

  task automatic count_lit(output int n);
    n = 0;
    wait_slot(6, 0);
    wait_slot(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (oe != 7'h00) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_rd [8];
    int         n, acks;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 3'd0; dat_w = 8'h00;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) exp_rd[i] = (i == 7) ? 8'h80 : 8'h00;
    for (int i = 0; i < 8; i++) begin
      wb_xfer(1'b0, 3'(i), 8'h00, rd);
      chk("reset_read", 12'(rd), 12'(exp_rd[i]));
    end

    wb_xfer(1'b1, 3'd2, 8'hFF, rd);
    wb_xfer(1'b0, 3'd2, 8'h00, rd);
    chk("mask2_readback", 12'(rd), 12'h07B);

    // row 0 with two columns at full brightness
    wb_xfer(1'b1, 3'd0, 8'h06, rd);
    wb_xfer(1'b1, 3'd7, 8'hFF, rd);
    wait_slot(6, 0);
    wait_slot(0, 100);
    chk("row0_oe", 12'(oe), 12'h007);
    chk("row0_o", 12'(o), 12'h001);

    count_lit(n);
    chk("lit_ff", 12'(n), 12'(7 * (255 - LIT_OFF)));
    wb_xfer(1'b1, 3'd7, 8'h00, rd);
    count_lit(n);
    chk("lit_00", 12'(n), 12'h0);
    wb_xfer(1'b1, 3'd7, 8'h40, rd);
    count_lit(n);
    chk("lit_40", 12'(n), 12'(7 * (64 - LIT_OFF)));

    // mask change mid-slot only takes effect in the row's next slot
    wb_xfer(1'b1, 3'd7, 8'h80, rd);
    wb_xfer(1'b1, 3'd3, 8'h40, rd);
    wait_slot(2, 0);
    wait_slot(3, 50);
    wb_xfer(1'b1, 3'd3, 8'h11, rd);
    wait_slot(3, 100);
    chk("mask3_old", 12'(oe), 12'h048);
    wait_slot(2, 0);
    wait_slot(3, 100);
    chk("mask3_new", 12'(oe), 12'h019);

    // held strobe acks every other cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd7;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_stb_acks", 12'(acks), 12'h4);

    // randomized traffic, including strobes without a cycle
    for (int t = 0; t < 250; t++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        stb = ($urandom_range(0, 1) == 1);
        cyc = 1'b0;
        we  = ($urandom_range(0, 1) == 1);
        adr = 3'($urandom_range(0, 7));
        dat_w = 8'($urandom);
      end
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
      wb_xfer(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 8'($urandom), rd);
    end
    for (int i = 0; i < 2 * FRAME; i++) @(negedge clk);

    // asynchronous reset mid-slot, then restart from row 0
    wb_xfer(1'b1, 3'd7, 8'hC0, rd);
    wb_xfer(1'b1, 3'd4, 8'h7F, rd);
    wait_slot(4, 77);
    wait_slot(4, 77);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", 12'(oe), 12'h0);
    chk("async_rst_o", 12'(o), 12'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("restart_oe", 12'(oe), 12'h001);
    chk("restart_o", 12'(o), 12'h001);
    wb_xfer(1'b0, 3'd4, 8'h00, rd);
    chk("restart_mask4", 12'(rd), 12'h000);
    wb_xfer(1'b0, 3'd7, 8'h00, rd);
    chk("restart_bright", 12'(rd), 12'h080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
